sorter_sequencer: RTL and testbench

SORTER_SEQUENCER -- requirements
Module: sorter_sequencer

---
 rtl/sorter_pkg.sv | 21 ++
 rtl/sorter_sequencer.sv | 159 +++++++++++++++
 tb/tb_sorter_sequencer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sorter_pkg.sv
// rtl/sorter_pkg.sv - shared types for the sorter and its sequencer
// Purpose: index width, the default per-key payload and the sequencer
// state encoding, shared by the sorter and the sorter_sequencer.
package sorter_pkg;

  localparam int INDEX_WIDTH = 8;

  // Default payload travelling with each key through the sorter.
  typedef struct packed {
    logic [INDEX_WIDTH-1:0] src;
    logic [INDEX_WIDTH-1:0] idx;
  } id_pair_s;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    READ  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/sorter_sequencer.sv
// rtl/sorter_sequencer.sv - frame sequencer wrapping an external sorter
// Purpose: accepts one upstream frame, feeds it into a sorter, waits for the
// sorter to settle, then reads the sorted slots out in ascending order.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   s_valid/s_ready/s_last/s_data/s_meta   upstream frame beats
//   m_valid/m_ready/m_last/m_data/m_meta   sorted output beats
//   srt_rst, srt_in_*                  drive the sorter (reset and load)
//   srt_out_*                          sorter read port (address out, data in)
//   busy                               high whenever not accepting a frame
//   overflow                           frame had more than ELEMENTS beats
module sorter_sequencer
  import sorter_pkg::*;
#(
  parameter int  ELEMENTS      = 64,
  parameter int  BIT_WIDTH     = 32,
  parameter type METADATA_TYPE = id_pair_s
) (
  input  logic                        clk,
  input  logic                        rst_n,

  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic                        s_last,
  input  logic [BIT_WIDTH-1:0]        s_data,
  input  METADATA_TYPE                s_meta,

  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        m_last,
  output logic [BIT_WIDTH-1:0]        m_data,
  output METADATA_TYPE                m_meta,

  output logic                        srt_rst,
  output logic                        srt_in_valid,
  output logic                        srt_in_last,
  output logic [BIT_WIDTH-1:0]        srt_in_data,
  output METADATA_TYPE                srt_in_metadata,

  input  logic                        srt_out_last,
  input  logic                        srt_out_valid,
  input  logic [BIT_WIDTH-1:0]        srt_out_data,
  input  METADATA_TYPE                srt_out_metadata,
  output logic [$clog2(ELEMENTS)-1:0] srt_out_address,

  output logic                        busy,
  output logic                        overflow
);

  localparam int AW = $clog2(ELEMENTS);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(ELEMENTS);

  seq_state_e      state;
  seq_state_e      next_state;
  logic [CW-1:0]   count;
  logic [CW-1:0]   rd_ptr;
  logic            accept;
  logic            out_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state      = state;
    s_ready         = 1'b0;
    m_valid         = 1'b0;
    m_last          = 1'b0;
    srt_out_address = rd_ptr[AW-1:0];
    m_data          = srt_out_data;
    m_meta          = srt_out_metadata;
    case (state)
      CLEAR: begin
        next_state = LOAD;
      end
      LOAD: begin
        s_ready = 1'b1;
        if (s_valid && s_last) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (srt_out_last) begin
          next_state = READ;
        end
      end
      READ: begin
        m_valid = 1'b1;
        m_last  = (rd_ptr == count - CW'(1));
        if (m_ready && m_last) begin
          next_state = CLEAR;
        end
      end
      default: begin
        next_state = CLEAR;
      end
    endcase
  end

  assign accept   = s_valid && s_ready;
  assign out_fire = m_valid && m_ready;

  // Upstream beats go straight into the sorter with no register stage.
  assign srt_in_valid    = accept;
  assign srt_in_last     = s_last;
  assign srt_in_data     = s_data;
  assign srt_in_metadata = s_meta;

  // The sorter resets synchronously, so hold it in reset for as long as
  // rst_n is low and for the one CLEAR cycle between frames.
  assign srt_rst = !rst_n || (state == CLEAR);
  assign busy    = (state != LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          count    <= '0;
          rd_ptr   <= '0;
          overflow <= 1'b0;
        end
        LOAD: begin
          // Beyond ELEMENTS the sorter keeps only the smallest keys, so the
          // count saturates and the frame is flagged instead.
          if (accept) begin
            if (count == FULL) begin
              overflow <= 1'b1;
            end else begin
              count <= count + CW'(1);
            end
          end
        end
        READ: begin
          if (out_fire) begin
            rd_ptr <= rd_ptr + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // A slot below count must always hold a valid key; data is passed as-is.
  slot_valid_a : assert property (
    @(posedge clk) disable iff (!rst_n)
    (state == READ && rd_ptr < count) |-> srt_out_valid
  );

endmodule

// File: tb/tb_sorter_sequencer.sv
// tb/tb_sorter_sequencer.sv - randomized self-checking bench for sorter_sequencer
module tb_sorter_sequencer;
  import sorter_pkg::*;

  localparam int N  = 8;
  localparam int W  = 32;
  localparam int AW = $clog2(N);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          s_valid, s_ready, s_last;
  logic [W-1:0]  s_data;
  id_pair_s      s_meta;
  logic          m_valid, m_ready, m_last;
  logic [W-1:0]  m_data;
  id_pair_s      m_meta;
  logic          srt_rst, srt_in_valid, srt_in_last;
  logic [W-1:0]  srt_in_data;
  id_pair_s      srt_in_metadata;
  logic          srt_out_last, srt_out_valid;
  logic [W-1:0]  srt_out_data;
  id_pair_s      srt_out_metadata;
  logic [AW-1:0] srt_out_address;
  logic          busy, overflow;

  sorter_sequencer #(
    .ELEMENTS(N), .BIT_WIDTH(W), .METADATA_TYPE(id_pair_s)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .s_data(s_data), .s_meta(s_meta),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .m_data(m_data), .m_meta(m_meta),
    .srt_rst(srt_rst), .srt_in_valid(srt_in_valid), .srt_in_last(srt_in_last),
    .srt_in_data(srt_in_data), .srt_in_metadata(srt_in_metadata),
    .srt_out_last(srt_out_last), .srt_out_valid(srt_out_valid),
    .srt_out_data(srt_out_data), .srt_out_metadata(srt_out_metadata),
    .srt_out_address(srt_out_address),
    .busy(busy), .overflow(overflow)
  );

  // Behavioural sorter: sorted slot array keeping the smallest N keys,
  // signalling done ELEMENTS+1 cycles after the last beat.
  logic [N-1:0][W-1:0] sk;
  id_pair_s [N-1:0]    sm;
  int                  sn;
  logic                draining;
  int                  dcnt;
  logic                sol;

  function automatic void sorter_insert(
    input  logic [N-1:0][W-1:0] ki, input id_pair_s [N-1:0] mi, input int n,
    input  logic [W-1:0] key, input id_pair_s meta,
    output logic [N-1:0][W-1:0] ko, output id_pair_s [N-1:0] mo, output int no);
    int pos;
    pos = 0;
    for (int i = 0; i < n; i++) if (ki[i] <= key) pos++;
    ko = ki;
    mo = mi;
    for (int i = N-1; i > 0; i--) begin
      if (i > pos) begin
        ko[i] = ki[i-1];
        mo[i] = mi[i-1];
      end
    end
    if (pos < N) begin
      ko[pos] = key;
      mo[pos] = meta;
    end
    no = (n < N) ? n + 1 : N;
  endfunction

  always @(posedge clk) begin
    logic [N-1:0][W-1:0] nk;
    id_pair_s [N-1:0]    nm;
    int                  nn;
    if (srt_rst) begin
      sn <= 0; draining <= 1'b0; dcnt <= 0; sol <= 1'b0;
    end else if (srt_in_valid) begin
      sorter_insert(sk, sm, sn, srt_in_data, srt_in_metadata, nk, nm, nn);
      sk <= nk; sm <= nm; sn <= nn;
      if (srt_in_last) begin
        draining <= 1'b1; dcnt <= N;
      end
    end else if (draining) begin
      if (dcnt == 0) sol <= 1'b1;
      else dcnt <= dcnt - 1;
    end
  end

  assign srt_out_last     = sol;
  assign srt_out_valid    = (int'(srt_out_address) < sn);
  assign srt_out_data     = sk[srt_out_address];
  assign srt_out_metadata = sm[srt_out_address];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic id_pair_s make_meta(input logic [W-1:0] k);
    id_pair_s r;
    r.src = k[7:0] ^ 8'hA5;
    r.idx = k[15:8] + 8'h3C;
    return r;
  endfunction

  logic [W-1:0] sent[$];

  task automatic send_frame(input logic [W-1:0] keys[$], input int gap_pct);
    int cyc;
    for (int i = 0; i < keys.size(); i++) begin
      @(posedge clk); #1;
      if ($urandom_range(99) < gap_pct) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data  = keys[i];
      s_meta  = make_meta(keys[i]);
      s_last  = (i == keys.size() - 1);
      @(negedge clk);
      cyc = 0;
      while (!s_ready && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      if (!s_ready) check("s_ready_timeout", 64'(s_ready), 64'(1));
      check("srt_in_valid", 64'(srt_in_valid), 64'(1));
      check("srt_in_data", 64'(srt_in_data), 64'(keys[i]));
      check("srt_in_last", 64'(srt_in_last), 64'(i == keys.size() - 1));
      sent.push_back(keys[i]);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Expected output: all sent keys sorted ascending, truncated to N.
  task automatic recv_frame(input int ready_pct, input int stop_after);
    logic [W-1:0] exp[$];
    int           n_out, idx, cyc;
    bit           ovf_exp, ovf_done, held;
    logic [W-1:0] hold_d;
    logic         hold_l;
    exp = sent;
    exp.sort();
    n_out   = (exp.size() > N) ? N : exp.size();
    ovf_exp = (sent.size() > N);
    idx = 0; cyc = 0; ovf_done = 0; held = 0;
    hold_d = '0; hold_l = 1'b0;
    while (idx < n_out && cyc < 500 && !(stop_after >= 0 && idx >= stop_after)) begin
      @(posedge clk); #1;
      m_ready = ($urandom_range(99) < ready_pct);
      @(negedge clk);
      cyc++;
      if (held) begin
        check("stall_valid", 64'(m_valid), 64'(1));
        check("stall_data", 64'(m_data), 64'(hold_d));
        check("stall_last", 64'(m_last), 64'(hold_l));
      end
      if (m_valid) begin
        if (!ovf_done) begin
          check("overflow", 64'(overflow), 64'(ovf_exp));
          ovf_done = 1;
        end
        if (m_ready) begin
          check("m_data", 64'(m_data), 64'(exp[idx]));
          check("m_meta", 64'(m_meta), 64'(make_meta(exp[idx])));
          check("m_last", 64'(m_last), 64'(idx == n_out - 1));
          idx++;
          held = 0;
        end else begin
          held = 1; hold_d = m_data; hold_l = m_last;
        end
      end
    end
    if (stop_after < 0 && idx < n_out) check("recv_timeout", 64'(idx), 64'(n_out));
    if (stop_after < 0) sent.delete();
  endtask

  task automatic rand_keys(input int n, output logic [W-1:0] q[$]);
    q.delete();
    // Low nibble is the beat index, so keys are unique within a frame.
    for (int i = 0; i < n; i++) q.push_back(($urandom_range(4000) << 4) | W'(i));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] kq[$];
    s_valid = 1'b1; s_last = 1'b0; s_data = 32'd5; s_meta = make_meta(32'd5);
    m_ready = 1'b0;
    #22;
    check("rst_s_ready", 64'(s_ready), 64'(0));
    check("rst_srt_in_valid", 64'(srt_in_valid), 64'(0));
    check("rst_m_valid", 64'(m_valid), 64'(0));
    check("rst_m_last", 64'(m_last), 64'(0));
    check("rst_srt_rst", 64'(srt_rst), 64'(1));
    check("rst_overflow", 64'(overflow), 64'(0));
    check("rst_busy", 64'(busy), 64'(1));
    s_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    #1;
    check("clear_srt_rst", 64'(srt_rst), 64'(1));
    check("clear_s_ready", 64'(s_ready), 64'(0));
    @(negedge clk);
    check("load_s_ready", 64'(s_ready), 64'(1));
    check("load_srt_rst", 64'(srt_rst), 64'(0));
    check("load_busy", 64'(busy), 64'(0));

    // Small frame, ascending readout.
    kq = {32'd5, 32'd3, 32'd9, 32'd1};
    send_frame(kq, 0);
    recv_frame(100, -1);

    // Single beat, then exactly one CLEAR cycle before s_ready returns.
    kq = {32'd7};
    send_frame(kq, 0);
    recv_frame(100, -1);
    @(negedge clk);
    check("gap_s_ready", 64'(s_ready), 64'(0));
    check("gap_srt_rst", 64'(srt_rst), 64'(1));
    @(negedge clk);
    check("gap_s_ready_back", 64'(s_ready), 64'(1));

    // Overflow: ten beats, smallest eight come out.
    kq.delete();
    for (int k = 10; k >= 1; k--) kq.push_back(W'(k));
    send_frame(kq, 0);
    recv_frame(100, -1);

    // Random back-pressure.
    rand_keys(8, kq);
    send_frame(kq, 20);
    recv_frame(50, -1);

    // Reset pulsed during READ after two outputs.
    rand_keys(8, kq);
    send_frame(kq, 0);
    recv_frame(100, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_m_valid", 64'(m_valid), 64'(0));
    check("midrst_srt_rst", 64'(srt_rst), 64'(1));
    check("midrst_s_ready", 64'(s_ready), 64'(0));
    check("midrst_overflow", 64'(overflow), 64'(0));
    sent.delete();
    m_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    kq = {32'd4, 32'd2};
    send_frame(kq, 0);
    recv_frame(100, -1);

    // Random frames of varying length, including overflowing ones.
    for (int f = 0; f < 5; f++) begin
      rand_keys($urandom_range(12, 1), kq);
      send_frame(kq, 25);
      recv_frame(70, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
